// File: rtl/vote_tally_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vote_tally_arbiter                                              |
// | Purpose  : Buffers per-channel event pulses in small saturating pending    |
// |            counters and retires them, one per cycle, through a shared      |
// |            round-robin increment path into a bank of per-channel tallies.  |
// |            A clear request starts a sequenced sweep that zeroes one tally  |
// |            (and its drop flag) per cycle.                                  |
// | Ports    : clk_in    - system clock, rising edge                           |
// |            rst_n_in  - asynchronous active-low reset                       |
// |            evt_in    - one-cycle event pulse per channel                   |
// |            clear_in  - one-cycle request to zero all tallies               |
// |            count_out - packed tallies, channel i at [i*COUNT_W +: COUNT_W] |
// |            grant_out - one-hot channel incremented last cycle              |
// |            wrap_out  - one-cycle pulse when a tally wraps / saturates      |
// |            drop_out  - sticky lost-event flag per channel                  |
// |            busy_out  - high while the clear sweep runs                     |
// | Options  : VOTE_TALLY_SATURATE_EN - tallies hold at MAX_COUNT instead of   |
// |            wrapping to zero.                                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vote_tally_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int COUNT_W   = 16,
  parameter int MAX_COUNT = 65535,
  parameter int PEND_W    = 3
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [NUM_CH-1:0]          evt_in,
  input  logic                       clear_in,
  output logic [NUM_CH*COUNT_W-1:0]  count_out,
  output logic [NUM_CH-1:0]          grant_out,
  output logic [NUM_CH-1:0]          wrap_out,
  output logic [NUM_CH-1:0]          drop_out,
  output logic                       busy_out
);

  localparam int                 IDX_W      = $clog2(NUM_CH);
  localparam logic [PEND_W-1:0]  C_PEND_MAX = '1;
  localparam logic [COUNT_W-1:0] C_MAX      = COUNT_W'(MAX_COUNT);
  localparam logic [IDX_W-1:0]   C_LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W:0]     C_NUM_EXT  = (IDX_W + 1)'(NUM_CH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sweep_idx_q, sweep_idx_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [PEND_W-1:0]  pend_q [NUM_CH];
  logic [PEND_W-1:0]  pend_d [NUM_CH];
  logic [COUNT_W-1:0] tally_q [NUM_CH];
  logic [COUNT_W-1:0] tally_d [NUM_CH];
  logic [NUM_CH-1:0]  grant_q, grant_d;
  logic [NUM_CH-1:0]  wrap_q, wrap_d;
  logic [NUM_CH-1:0]  drop_q, drop_d;
  logic               busy_q, busy_d;

  logic [NUM_CH-1:0]  pend_nz;
  logic               arb_en;
  logic               arb_found;
  logic [IDX_W:0]     arb_cand_ext;
  logic [IDX_W-1:0]   arb_cand;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign pend_nz[gi]                          = |pend_q[gi];
      assign count_out[gi*COUNT_W +: COUNT_W]     = tally_q[gi];
    end
  endgenerate

  // Run/sweep control. A clear accepted in RUN suppresses that cycle's grant.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    arb_en      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (clear_in) begin
          state_d     = ST_SWEEP;
          sweep_idx_d = '0;
        end else begin
          arb_en = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (sweep_idx_q == C_LAST_IDX) begin
          state_d     = ST_RUN;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
    busy_d = (state_d == ST_SWEEP);
  end

  // Round-robin search starting one past the last granted channel. The
  // candidate index is last+k reduced mod NUM_CH with a single conditional
  // subtract, which also covers non-power-of-two channel counts.
  always_comb begin
    grant_d      = '0;
    last_grant_d = last_grant_q;
    arb_found    = 1'b0;
    arb_cand_ext = '0;
    arb_cand     = '0;
    if (arb_en) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        arb_cand_ext = {1'b0, last_grant_q} + (IDX_W + 1)'(k);
        if (arb_cand_ext >= C_NUM_EXT) begin
          arb_cand_ext = arb_cand_ext - C_NUM_EXT;
        end
        arb_cand = arb_cand_ext[IDX_W-1:0];
        if (!arb_found && pend_nz[arb_cand]) begin
          arb_found          = 1'b1;
          grant_d[arb_cand]  = 1'b1;
          last_grant_d       = arb_cand;
        end
      end
    end
  end

  // Per-channel pending, tally, wrap and drop update. Sweep clearing and
  // grants never coincide because grants are only made in RUN; a drop in the
  // same cycle as its channel's sweep slot still sets the flag.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pend_d[i]  = pend_q[i];
      tally_d[i] = tally_q[i];
      wrap_d[i]  = 1'b0;
      drop_d[i]  = drop_q[i];

      if (state_q == ST_SWEEP && sweep_idx_q == IDX_W'(i)) begin
        tally_d[i] = '0;
        drop_d[i]  = 1'b0;
      end

      if (evt_in[i] && !grant_d[i]) begin
        if (pend_q[i] == C_PEND_MAX) begin
          drop_d[i] = 1'b1;
        end else begin
          pend_d[i] = pend_q[i] + PEND_W'(1);
        end
      end else if (!evt_in[i] && grant_d[i]) begin
        pend_d[i] = pend_q[i] - PEND_W'(1);
      end

      if (grant_d[i]) begin
        if (tally_q[i] == C_MAX) begin
`ifdef VOTE_TALLY_SATURATE_EN
          tally_d[i] = tally_q[i];
`else
          tally_d[i] = '0;
`endif
          wrap_d[i] = 1'b1;
        end else begin
          tally_d[i] = tally_q[i] + COUNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_RUN;
      sweep_idx_q  <= '0;
      last_grant_q <= C_LAST_IDX;
      grant_q      <= '0;
      wrap_q       <= '0;
      drop_q       <= '0;
      busy_q       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_q[i]  <= '0;
        tally_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      sweep_idx_q  <= sweep_idx_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wrap_q       <= wrap_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_q[i]  <= pend_d[i];
        tally_q[i] <= tally_d[i];
      end
    end
  end

  assign grant_out = grant_q;
  assign wrap_out  = wrap_q;
  assign drop_out  = drop_q;
  assign busy_out  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_tally_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vote_tally_arbiter                                           |
// | Purpose  : Directed self-checking bench. One instance uses the default     |
// |            parameters; a second uses MAX_COUNT=3 for the wrap sequence.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_vote_tally_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [3:0]  evt, evt_w;
  logic        clr, clr_w;
  logic [63:0] cnt, cnt_w;
  logic [3:0]  gnt, gnt_w, wrap, wrap_w, drop, drop_w;
  logic        busy, busy_w;

  always #5 clk_in = ~clk_in;

  vote_tally_arbiter #(.NUM_CH(4), .COUNT_W(16), .MAX_COUNT(65535), .PEND_W(3)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .evt_in(evt), .clear_in(clr),
    .count_out(cnt), .grant_out(gnt), .wrap_out(wrap), .drop_out(drop), .busy_out(busy)
  );

  vote_tally_arbiter #(.NUM_CH(4), .COUNT_W(16), .MAX_COUNT(3), .PEND_W(3)) dut_w (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .evt_in(evt_w), .clear_in(clr_w),
    .count_out(cnt_w), .grant_out(gnt_w), .wrap_out(wrap_w), .drop_out(drop_w), .busy_out(busy_w)
  );

`ifdef VOTE_TALLY_SATURATE_EN
  localparam logic [63:0] C_WRAP_FINAL = 64'h0000_0000_0003_0000;
`else
  localparam logic [63:0] C_WRAP_FINAL = 64'h0000_0000_0000_0000;
`endif

  typedef struct {
    logic [3:0]  evt;
    logic        clr;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  wrap;
    logic [3:0]  drop;
    logic [63:0] cnt;
  } vec_t;

  vec_t tbl_single [3];
  vec_t tbl_wrap   [9];

  int n_checks = 0;
  int n_fail   = 0;
  int n_grants;
  int tally_sum;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    evt = '0; evt_w = '0; clr = 1'b0; clr_w = 1'b0;
    repeat (2) tick();
    rst_n_in = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input bit use_w, input string tag);
    if (use_w) begin evt_w = v.evt; clr_w = v.clr; end
    else       begin evt   = v.evt; clr   = v.clr; end
    tick();
    if (use_w) begin
      chk({tag, " grant"}, 64'(gnt_w),  64'(v.grant));
      chk({tag, " busy"},  64'(busy_w), 64'(v.busy));
      chk({tag, " wrap"},  64'(wrap_w), 64'(v.wrap));
      chk({tag, " drop"},  64'(drop_w), 64'(v.drop));
      chk({tag, " count"}, cnt_w,       v.cnt);
    end else begin
      chk({tag, " grant"}, 64'(gnt),  64'(v.grant));
      chk({tag, " busy"},  64'(busy), 64'(v.busy));
      chk({tag, " wrap"},  64'(wrap), 64'(v.wrap));
      chk({tag, " drop"},  64'(drop), 64'(v.drop));
      chk({tag, " count"}, cnt,       v.cnt);
    end
  endtask

  initial begin
    // Single event on channel 2 (count at [47:32]).
    tbl_single[0] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 64'h0};
    tbl_single[1] = '{4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0000, 64'h0000_0001_0000_0000};
    tbl_single[2] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 64'h0000_0001_0000_0000};

    // Four spaced events on channel 1 with MAX_COUNT=3 (count at [31:16]).
    tbl_wrap[0] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 64'h0};
    tbl_wrap[1] = '{4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0000, 64'h0000_0000_0001_0000};
    tbl_wrap[2] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 64'h0000_0000_0001_0000};
    tbl_wrap[3] = '{4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0000, 64'h0000_0000_0002_0000};
    tbl_wrap[4] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 64'h0000_0000_0002_0000};
    tbl_wrap[5] = '{4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0000, 64'h0000_0000_0003_0000};
    tbl_wrap[6] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 64'h0000_0000_0003_0000};
    tbl_wrap[7] = '{4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0000, C_WRAP_FINAL};
    tbl_wrap[8] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, C_WRAP_FINAL};

    do_reset();
    chk("reset count",  cnt,        64'h0);
    chk("reset grant",  64'(gnt),   64'h0);
    chk("reset wrap",   64'(wrap),  64'h0);
    chk("reset drop",   64'(drop),  64'h0);
    chk("reset busy",   64'(busy),  64'h0);
    chk("reset count_w", cnt_w,     64'h0);

    for (int i = 0; i < 3; i++) run_vec(tbl_single[i], 1'b0, $sformatf("single[%0d]", i));
    for (int i = 0; i < 9; i++) run_vec(tbl_wrap[i],   1'b1, $sformatf("wrap[%0d]", i));

    // Round robin: all channels for 8 edges; grants rotate 0,1,2,3 from edge 1.
    do_reset();
    for (int k = 0; k <= 33; k++) begin
      evt = (k < 8) ? 4'b1111 : 4'b0000;
      tick();
      if (k == 0 || k == 33) chk($sformatf("rr grant e%0d", k), 64'(gnt), 64'h0);
      else chk($sformatf("rr grant e%0d", k), 64'(gnt), 64'(4'b0001 << ((k - 1) % 4)));
    end
    chk("rr counts", cnt, 64'h0008_0008_0008_0008);
    chk("rr drop",   64'(drop), 64'h0);

    // Overload: 20 edges of all-channel events saturate every pending counter.
    do_reset();
    n_grants = 0;
    for (int k = 0; k < 80; k++) begin
      evt = (k < 20) ? 4'b1111 : 4'b0000;
      tick();
      n_grants += $countones(gnt);
    end
    tally_sum = 0;
    for (int i = 0; i < 4; i++) tally_sum += int'(cnt[16*i +: 16]);
    chk("drop flags",   64'(drop),      64'hF);
    chk("drop sum",     64'(tally_sum), 64'(n_grants));
    chk("drop grants",  64'(n_grants),  64'd47);
    chk("drop counts",  cnt,            64'h000B_000C_000C_000C);

    // Clear sweep with a concurrent channel-0 event and an ignored re-clear.
    evt = 4'b0001; clr = 1'b1;
    tick();  // edge t
    chk("clr t busy",  64'(busy), 64'h1);
    chk("clr t grant", 64'(gnt),  64'h0);
    chk("clr t count", cnt,       64'h000B_000C_000C_000C);
    evt = 4'b0000; clr = 1'b0;
    tick();  // t+1
    chk("clr t1 count", cnt,       64'h000B_000C_000C_0000);
    chk("clr t1 drop",  64'(drop), 64'hE);
    clr = 1'b1;
    tick();  // t+2
    clr = 1'b0;
    chk("clr t2 count", cnt,       64'h000B_000C_0000_0000);
    chk("clr t2 busy",  64'(busy), 64'h1);
    tick();  // t+3
    chk("clr t3 count", cnt,       64'h000B_0000_0000_0000);
    chk("clr t3 drop",  64'(drop), 64'h8);
    chk("clr t3 busy",  64'(busy), 64'h1);
    tick();  // t+4
    chk("clr t4 count", cnt,       64'h0);
    chk("clr t4 drop",  64'(drop), 64'h0);
    chk("clr t4 busy",  64'(busy), 64'h0);
    chk("clr t4 grant", 64'(gnt),  64'h0);
    tick();  // t+5
    chk("clr t5 grant", 64'(gnt),  64'h1);
    chk("clr t5 count", cnt,       64'h0000_0000_0000_0001);
    tick();  // t+6
    chk("clr t6 busy",  64'(busy), 64'h0);
    chk("clr t6 grant", 64'(gnt),  64'h0);

    // Asynchronous reset at sweep index 2.
    evt = 4'b0110;
    tick();
    evt = 4'b0000;
    repeat (3) tick();
    chk("pre-sweep count", cnt, 64'h0000_0001_0001_0001);
    clr = 1'b1;
    tick();  // t
    clr = 1'b0;
    repeat (2) tick();  // t+2: sweep index is now 2
    chk("mid-sweep busy", 64'(busy), 64'h1);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("async count", cnt,       64'h0);
    chk("async busy",  64'(busy), 64'h0);
    chk("async grant", 64'(gnt),  64'h0);
    chk("async drop",  64'(drop), 64'h0);
    #2;
    rst_n_in = 1'b1;
    evt = 4'b0001;
    tick();
    evt = 4'b0000;
    chk("post-rst busy", 64'(busy), 64'h0);
    tick();
    chk("post-rst grant", 64'(gnt), 64'h1);
    chk("post-rst count", cnt,      64'h0000_0000_0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
